// File: rtl/pipelined_ripple_adder.sv
// Ripple-carry adder cut into WIDTH/STAGE_BITS registered slices with a valid/ready
// handshake. The whole pipeline advances in lockstep and freezes while the output stalls.
module pipelined_ripple_adder #(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 2,
    parameter bit SIGNED     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = (STAGE_BITS > 0) ? (WIDTH / STAGE_BITS) : 1;

    if (WIDTH < 1 || STAGE_BITS < 1 || STAGE_BITS > WIDTH || (WIDTH % STAGE_BITS) != 0) begin : gen_param_check
        $error("pipelined_ripple_adder: illegal WIDTH/STAGE_BITS combination");
    end

    function automatic logic [STAGE_BITS:0] slice_add(input logic [STAGE_BITS-1:0] x,
                                                      input logic [STAGE_BITS-1:0] y,
                                                      input logic                  ci);
        return {1'b0, x} + {1'b0, y} + {{STAGE_BITS{1'b0}}, ci};
    endfunction

    // Carry into the MSB is recovered as x ^ y ^ s at that bit.
    function automatic logic ovf_flag(input logic x_msb, input logic y_msb,
                                      input logic s_msb, input logic co);
        return SIGNED ? (x_msb ^ y_msb ^ s_msb ^ co) : co;
    endfunction

    logic                  advance;
    logic [STAGES-1:0]     vld_q, vld_d, ld;
    logic [STAGES-1:0]     c_q, c_d;
    logic                  ovf_q, ovf_d;
    logic [WIDTH-1:0]      a_q [STAGES];
    logic [WIDTH-1:0]      b_q [STAGES];
    logic [WIDTH-1:0]      s_q [STAGES];
    logic [WIDTH-1:0]      a_d [STAGES];
    logic [WIDTH-1:0]      b_d [STAGES];
    logic [WIDTH-1:0]      s_d [STAGES];
    logic [STAGE_BITS-1:0] xs  [STAGES];
    logic [STAGE_BITS-1:0] ys  [STAGES];
    logic [STAGE_BITS:0]   r_sl [STAGES];

    assign advance   = !vld_q[STAGES-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Operands shift down by one slice per stage (skew); sum slices enter at the top
    // and shift down, so the full sum is aligned when it leaves the last stage.
    always_comb begin
        vld_d = '0;
        ld    = '0;
        c_d   = '0;

        xs[0]    = a[STAGE_BITS-1:0];
        ys[0]    = b[STAGE_BITS-1:0];
        r_sl[0]  = slice_add(xs[0], ys[0], cin);
        a_d[0]   = a >> STAGE_BITS;
        b_d[0]   = b >> STAGE_BITS;
        s_d[0]   = WIDTH'(r_sl[0][STAGE_BITS-1:0]) << (WIDTH - STAGE_BITS);
        c_d[0]   = r_sl[0][STAGE_BITS];
        vld_d[0] = in_valid;
        ld[0]    = advance & in_valid;

        for (int k = 1; k < STAGES; k++) begin
            xs[k]    = a_q[k-1][STAGE_BITS-1:0];
            ys[k]    = b_q[k-1][STAGE_BITS-1:0];
            r_sl[k]  = slice_add(xs[k], ys[k], c_q[k-1]);
            a_d[k]   = a_q[k-1] >> STAGE_BITS;
            b_d[k]   = b_q[k-1] >> STAGE_BITS;
            s_d[k]   = (s_q[k-1] >> STAGE_BITS)
                     | (WIDTH'(r_sl[k][STAGE_BITS-1:0]) << (WIDTH - STAGE_BITS));
            c_d[k]   = r_sl[k][STAGE_BITS];
            vld_d[k] = vld_q[k-1];
            ld[k]    = advance & vld_q[k-1];
        end

        ovf_d = ovf_flag(xs[STAGES-1][STAGE_BITS-1], ys[STAGES-1][STAGE_BITS-1],
                         r_sl[STAGES-1][STAGE_BITS-1], r_sl[STAGES-1][STAGE_BITS]);
    end

    // Data registers only load behind a valid entry, so bubbles leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            if (advance) begin
                vld_q <= vld_d;
            end
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (ld[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder: unsigned 4-stage, signed 4-stage and 1-stage builds.
module tb_pipelined_ripple_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       m_in_valid, m_in_ready, m_cin, m_out_valid, m_out_ready, m_cout, m_ovf;
    logic [7:0] m_a, m_b, m_sum;
    logic       s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [7:0] s_a, s_b, s_sum;
    logic       w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout, w_ovf;
    logic [7:0] w_a, w_b, w_sum;

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(8), .STAGE_BITS(2), .SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .sum(m_sum), .cout(m_cout), .ovf(m_ovf));

    pipelined_ripple_adder #(.WIDTH(8), .STAGE_BITS(2), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf));

    pipelined_ripple_adder #(.WIDTH(8), .STAGE_BITS(8), .SIGNED(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] es, input logic ec);
        chk({tag, "_valid"}, 16'(m_out_valid), 16'd1);
        chk({tag, "_sum"},   16'(m_sum),       16'(es));
        chk({tag, "_cout"},  16'(m_cout),      16'(ec));
        chk({tag, "_ovf"},   16'(m_ovf),       16'(ec));
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task m_drive(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        m_in_valid = 1'b1; m_a = av; m_b = bv; m_cin = cv;
    endtask

    // Idle inputs carry junk operands that must never reach the output.
    task m_idle();
        m_in_valid = 1'b0; m_a = 8'hC3; m_b = 8'h5A; m_cin = 1'b1;
    endtask

    task s_drive(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        s_in_valid = 1'b1; s_a = av; s_b = bv; s_cin = cv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        m_idle(); m_out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = 8'h00; s_b = 8'h00; s_cin = 1'b0; s_out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = 8'h00; w_b = 8'h00; w_cin = 1'b0; w_out_ready = 1'b1;

        #2 rst = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 16'(m_out_valid), 16'd0);
        chk("rst_sum",       16'(m_sum),       16'd0);
        chk("rst_cout",      16'(m_cout),      16'd0);
        chk("rst_ovf",       16'(m_ovf),       16'd0);
        chk("rst_in_ready",  16'(m_in_ready),  16'd1);
        chk("rst_s_valid",   16'(s_out_valid), 16'd0);
        chk("rst_w_valid",   16'(w_out_valid), 16'd0);

        // 0xFF + 0x01 on the first edge after release
        rst = 1'b0;
        m_drive(8'hFF, 8'h01, 1'b0);
        #1 chk("t1_in_ready", 16'(m_in_ready), 16'd1);
        tick(); m_idle();
        for (int i = 1; i < 4; i++) begin
            chk("t1_latency_gap", 16'(m_out_valid), 16'd0);
            tick();
        end
        chk_res("t1", 8'h00, 1'b1);
        tick();
        chk("t1_drained", 16'(m_out_valid), 16'd0);

        // four back-to-back transfers
        m_drive(8'h01, 8'h02, 1'b0); tick();
        m_drive(8'h10, 8'h10, 1'b0); tick();
        m_drive(8'hF0, 8'h0F, 1'b1); tick();
        m_drive(8'h80, 8'h80, 1'b0); tick();
        m_idle();
        chk_res("b2b0", 8'h03, 1'b0); tick();
        chk_res("b2b1", 8'h20, 1'b0); tick();
        chk_res("b2b2", 8'h00, 1'b1); tick();
        chk_res("b2b3", 8'h00, 1'b1); tick();
        chk("b2b_drained", 16'(m_out_valid), 16'd0);

        // bubble between two transfers is preserved
        m_drive(8'h33, 8'h44, 1'b0); tick();
        m_idle(); tick();
        m_drive(8'h05, 8'h06, 1'b1); tick();
        m_idle(); tick();
        chk_res("bub_x", 8'h77, 1'b0); tick();
        chk("bub_gap", 16'(m_out_valid), 16'd0); tick();
        chk_res("bub_y", 8'h0C, 1'b0); tick();
        chk("bub_drained", 16'(m_out_valid), 16'd0);

        // output stall for 3 cycles with an offered operand set that must be refused
        m_drive(8'h11, 8'h22, 1'b0); tick();
        m_drive(8'h40, 8'h40, 1'b0); tick();
        m_drive(8'hFE, 8'h03, 1'b0); tick();
        m_drive(8'h7F, 8'h80, 1'b1); tick();
        m_drive(8'hAA, 8'hAA, 1'b0);
        m_out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_res("stall_hold", 8'h33, 1'b0);
            chk("stall_in_ready", 16'(m_in_ready), 16'd0);
            tick();
        end
        m_idle();
        m_out_ready = 1'b1;
        #1 chk("stall_release_ready", 16'(m_in_ready), 16'd1);
        chk_res("stall_r0", 8'h33, 1'b0); tick();
        chk_res("stall_r1", 8'h80, 1'b0); tick();
        chk_res("stall_r2", 8'h01, 1'b1); tick();
        chk_res("stall_r3", 8'h00, 1'b1); tick();
        chk("stall_no_extra0", 16'(m_out_valid), 16'd0); tick();
        chk("stall_no_extra1", 16'(m_out_valid), 16'd0);

        // asynchronous reset while a result is held on the outputs
        m_drive(8'h12, 8'h34, 1'b0); tick();
        m_idle(); tick(); tick(); tick();
        m_out_ready = 1'b0;
        #1 chk_res("hold_before_rst", 8'h46, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 16'(m_out_valid), 16'd0);
        chk("async_rst_sum",   16'(m_sum),       16'd0);
        chk("async_rst_ready", 16'(m_in_ready),  16'd1);
        tick();
        rst = 1'b0;
        m_out_ready = 1'b1;

        // reset pulse in cycle 2 after two transfers
        m_drive(8'h01, 8'h01, 1'b0); tick();
        m_drive(8'h02, 8'h02, 1'b0); tick();
        m_idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 16'(m_out_valid), 16'd0);
        chk("mid_rst_ready", 16'(m_in_ready),  16'd1);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_out_valid) cnt++;
            tick();
        end
        chk("mid_rst_no_result", 16'(cnt), 16'd0);

        // two's complement overflow
        s_drive(8'h7F, 8'h01, 1'b0); tick();
        s_drive(8'hFF, 8'h01, 1'b0); tick();
        s_drive(8'h80, 8'hFF, 1'b0); tick();
        s_in_valid = 1'b0; tick();
        chk("sgn0_valid", 16'(s_out_valid), 16'd1);
        chk("sgn0_sum",   16'(s_sum),       16'h80);
        chk("sgn0_ovf",   16'(s_ovf),       16'd1);
        chk("sgn0_cout",  16'(s_cout),      16'd0);
        tick();
        chk("sgn1_valid", 16'(s_out_valid), 16'd1);
        chk("sgn1_sum",   16'(s_sum),       16'h00);
        chk("sgn1_ovf",   16'(s_ovf),       16'd0);
        chk("sgn1_cout",  16'(s_cout),      16'd1);
        tick();
        chk("sgn2_sum",   16'(s_sum),       16'h7F);
        chk("sgn2_ovf",   16'(s_ovf),       16'd1);
        chk("sgn2_cout",  16'(s_cout),      16'd1);

        // single-stage build: latency 1
        w_in_valid = 1'b1; w_a = 8'hAA; w_b = 8'h55; w_cin = 1'b1;
        #1 chk("wide_c0_valid", 16'(w_out_valid), 16'd0);
        tick();
        w_in_valid = 1'b0; w_a = 8'h0F; w_b = 8'h0F; w_cin = 1'b0;
        chk("wide_valid", 16'(w_out_valid), 16'd1);
        chk("wide_sum",   16'(w_sum),       16'h00);
        chk("wide_cout",  16'(w_cout),      16'd1);
        chk("wide_ovf",   16'(w_ovf),       16'd1);
        tick();
        chk("wide_drained", 16'(w_out_valid), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_ripple_adder.md
PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits, at least 1.
REQ-002 SHALL have parameter STAGE_BITS, default 2: bits added per pipeline stage; 1 <= STAGE_BITS <= WIDTH, and WIDTH mod STAGE_BITS = 0.
REQ-003 SHALL have parameter SIGNED, default 0: selects the ovf meaning (0 unsigned, 1 two's complement).
REQ-004 SHALL derive local STAGES = WIDTH/STAGE_BITS and reject illegal parameter combinations at elaboration.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-009 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-010 SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-011 SHALL have port out_valid, output, 1 bit: the result outputs hold a valid result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-013 SHALL have ports sum (output, WIDTH bits), cout (output, 1 bit: carry out of the MSB) and ovf (output, 1 bit: overflow flag).

Function
REQ-014 SHALL split the add into STAGES slices; stage k adds bits [k*STAGE_BITS +: STAGE_BITS] plus the carry registered by stage k-1 (stage 0 uses cin).
REQ-015 SHALL skew-buffer each operand slice so that it reaches stage k k cycles after acceptance, and deskew the sum slices so that all WIDTH sum bits leave together.
REQ-016 SHALL carry one valid bit per stage; all stages advance together on advance = !out_valid | out_ready.
REQ-017 SHALL drive in_ready = advance combinationally; an operand set transfers on any cycle with in_valid & in_ready.
REQ-018 SHALL insert a bubble (valid 0) into stage 0 on an advancing cycle with no transfer; bubbles are not collapsed.
REQ-019 SHALL have a latency of STAGES cycles: operands transferred in cycle n appear with out_valid=1 in cycle n+STAGES when there is no stall.
REQ-020 SHALL hold sum, cout, ovf and out_valid stable, and freeze every stage, while out_valid=1 and out_ready=0.
REQ-021 SHALL complete a result transfer on out_valid & out_ready; a new transfer may occur in the same cycle (throughput 1 result per cycle).
REQ-022 SHALL compute {cout,sum} = a + b + cin, with modulo-2^WIDTH wrap-around on sum.
REQ-023 SHALL set ovf = cout when SIGNED=0, and ovf = (carry into MSB) XOR cout when SIGNED=1.
REQ-024 SHALL deliver results in acceptance order with no loss or duplication under any in_valid/out_ready pattern.
REQ-025 SHALL ignore a, b and cin whenever no transfer occurs.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear all stage valid bits and the carry, operand and sum registers to 0, giving out_valid=0, sum=0, cout=0 and ovf=0.
REQ-027 SHALL drive in_ready=1 during and after reset, because out_valid=0.
REQ-028 SHALL discard operations in flight when rst is asserted mid-operation; no result of them may appear after release.
REQ-029 SHALL accept a transfer on the first rising edge with rst deasserted.

Verification (WIDTH=8, STAGE_BITS=2 unless stated)
REQ-030 SHALL cover: a=0xFF, b=0x01, cin=0 transferred in cycle 0 -> cycle 4 shows out_valid=1, sum=0x00, cout=1, ovf=1.
REQ-031 SHALL cover: four back-to-back transfers (0x01+0x02, 0x10+0x10, 0xF0+0x0F with cin=1, 0x80+0x80) with out_ready=1 -> sums 0x03, 0x20, 0x00 (cout=1), 0x00 (cout=1) in cycles 4..7.
REQ-032 SHALL cover: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, outputs frozen; on release the remaining results arrive in order with none lost.
REQ-033 SHALL cover: SIGNED=1 -> 0x7F+0x01 gives sum=0x80, ovf=1, cout=0; 0xFF+0x01 gives sum=0x00, ovf=0, cout=1.
REQ-034 SHALL cover: rst pulse in cycle 2 after two transfers -> out_valid=0 immediately and no result appears in the following 8 cycles.
REQ-035 SHALL cover: STAGE_BITS=8 -> latency 1, with 0xAA+0x55+cin=1 giving sum=0x00, cout=1.
